// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg
// Shared immediate-format encodings and request/error records for the
// immediate encoder.
// Revision: 1.0
// ============================================================================
package riscv_pkg;

  // imm_src encodings, identical to the decode-side immediate generator
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic [2:0]  imm_src;
    logic [31:0] imm_val;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } enc_req_t;

  typedef struct packed {
    logic range;
    logic align;
    logic fmt;
  } enc_err_t;

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// imm_pack
// Combinational packer: scatters the immediate and register fields into an
// RV32I instruction word. Unused fields are zero; illegal formats give 0.
// Revision: 1.0
// ============================================================================
module imm_pack
  import riscv_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] instr
);

  logic [31:0] imm;
  assign imm = req.imm_val;

  // Select the bit scatter for the requested format
  always_comb begin
    instr = 32'h0;
    case (req.imm_src)
      IMM_I: instr = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      IMM_S: instr = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
      IMM_B: instr = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                      imm[4:1], imm[11], req.opcode};
      IMM_U: instr = {imm[31:12], req.rd, req.opcode};
      IMM_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
      default: instr = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// imm_encoder
// Two-stage valid/ready immediate encoder: stage 1 registers the request and
// its range/alignment/format checks, stage 2 registers the packed instruction.
// Keeps a saturating count of delivered results carrying any error flag.
// Revision: 1.0
// ============================================================================
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_src,
  input  logic [31:0]          imm_val,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 range_err,
  output logic                 align_err,
  output logic                 fmt_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  enc_req_t    req_in;
  enc_req_t    s1_req;
  enc_err_t    chk_err;
  enc_err_t    s1_err;
  enc_err_t    s2_err;
  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic [31:0] pack_instr;
  logic        in_xfer;
  logic        out_xfer;
  logic        s2_free;
  logic        s1_advance;

  assign req_in = '{imm_src: imm_src, imm_val: imm_val, opcode: opcode,
                    rd: rd, funct3: funct3, rs1: rs1, rs2: rs2};

  // Stage 2 can take a new entry when empty or when it is draining now;
  // clr blocks acceptance so a flush never races a new request.
  assign s2_free    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_free;
  assign in_ready   = !clr && (!s1_valid || s2_free);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = s2_valid && out_ready;

  // Range/alignment/format checks on the incoming request
  always_comb begin
    chk_err = '0;
    case (imm_src)
      IMM_I, IMM_S: chk_err.range = !((&imm_val[31:11]) || !(|imm_val[31:11]));
      IMM_B: begin
        chk_err.range = !((&imm_val[31:12]) || !(|imm_val[31:12]));
        chk_err.align = imm_val[0];
      end
      IMM_U: chk_err.range = |imm_val[11:0];
      IMM_J: begin
        chk_err.range = !((&imm_val[31:20]) || !(|imm_val[31:20]));
        chk_err.align = imm_val[0];
      end
      default: chk_err.fmt = 1'b1;
    endcase
  end

  imm_pack u_pack (
    .req   (s1_req),
    .instr (pack_instr)
  );

  // Stage 1: capture request and check results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_err   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_req   <= req_in;
      s1_err   <= chk_err;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: capture packed word; held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= '0;
    end else if (clr) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= '0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      s2_instr <= pack_instr;
      s2_err   <= s1_err;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  // Saturating count of delivered results that carry any error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (out_xfer && (|s2_err) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign instr     = s2_instr;
  assign range_err = s2_err.range;
  assign align_err = s2_err.align;
  assign fmt_err   = s2_err.fmt;

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate plus register/opcode fields into a 32-bit RV32I instruction word.
- Supports I/S/B/U/J formats using the same imm_src encoding as the decode side.
- Used by the instruction-memory loader and self-checking benches to build instruction streams on-chip.
- 2-stage valid/ready pipeline that also checks range and alignment and keeps a saturating error count.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: flush pipeline, zero err_cnt.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept.
- imm_src  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
- imm_val  input  32  immediate as a signed byte offset / value (same value the decoder would produce).
- opcode  input  7  instr[6:0].
- rd  input  5  instr[11:7] (I/U/J only).
- funct3  input  3  instr[14:12] (I/S/B only).
- rs1  input  5  instr[19:15] (I/S/B only).
- rs2  input  5  instr[24:20] (S/B only).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- instr  output  32  encoded instruction.
- range_err  output  1  immediate not representable in the format.
- align_err  output  1  B/J immediate with imm_val[0]=1.
- fmt_err  output  1  illegal imm_src.
- err_cnt  output  ERR_CNT_W  count of transferred results with any error flag, saturating.

Behaviour:
- Reset (async, rst_n=0): both stage valids 0, out_valid=0, instr=0, all error flags 0, err_cnt=0.
  - in_ready is 1 one cycle after rst_n deasserts.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Inputs are sampled only on an input transfer.
  - in_valid must not depend on in_ready.
- Stage 1 (check) registers the fields and computes the error flags.
  - I/S: range_err unless imm_val[31:11] is all equal.
  - B: range_err unless imm_val[31:12] is all equal. align_err = imm_val[0].
  - U: range_err unless imm_val[11:0] == 0.
  - J: range_err unless imm_val[31:20] is all equal. align_err = imm_val[0].
  - Illegal imm_src: fmt_err=1, instr=0.
- Stage 2 (pack) registers instr. Fields not used by a format are zero (rd in S/B; funct3/rs1/rs2 where unused).
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Errored entries still pack the truncated bits and still flow to the output.
- Latency and throughput:
  - Latency: out_valid rises 2 cycles after an input transfer when there is no backpressure.
  - Throughput: 1 per cycle.
- Backpressure:
  - Each stage advances when its successor is empty or is transferring this cycle.
  - in_ready = !s1_valid || s1_advance.
  - With out_ready=0 the pipeline holds 2 entries and then deasserts in_ready.
  - instr and the error flags stay stable while out_valid && !out_ready.
  - Order is preserved; no drop, no duplication.
- err_cnt increments by 1 on each output transfer with any error flag set, and saturates at all-ones.
- clr has priority over all other events in the same cycle:
  - Clears both stages and err_cnt.
  - An input presented that cycle is not accepted (in_ready=0 during clr).
- rst_n asserted mid-transfer: in-flight entries are discarded and outputs go to reset values immediately.

Decomposition:
- Shared package (riscv_pkg):
  - imm_src constants IMM_I, IMM_S, IMM_B, IMM_U, IMM_J.
  - Packed struct enc_req_t (imm_src, imm_val, opcode, rd, funct3, rs1, rs2).
  - Packed struct enc_err_t (range, align, fmt).
- Sub-module imm_pack: combinational field packer used by stage 2. The top holds the handshake, the checks and the counter.

Test Plan:
- I-type, opcode 7'h13, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF, out_ready=1 -> instr 32'hFFF00093 exactly 2 cycles after accept, all error flags 0.
- S-type, opcode 7'h23, funct3=2, rs1=2, rs2=5, imm=8 -> 32'h00512423.
- B-type, opcode 7'h63, rs1=rs2=0, imm=-4 -> 32'hFE000EE3.
- U-type, opcode 7'h37, rd=10, imm=32'h12345000 -> 32'h12345537.
- J-type, opcode 7'h6F, rd=1, imm=32'h800 -> 32'h001000EF.
- Error cases, in one back-to-back burst: I imm=32'h800 -> range_err; J imm=3 -> align_err; imm_src=3'b111 -> fmt_err with instr=0. err_cnt=3 after all three transfer.
- Backpressure: out_ready=0 for 5 cycles while offering 3 requests -> exactly 2 accepted, in_ready=0 while full. After release all 3 emerge in order, one per cycle.
- Async reset: rst_n pulsed low with 2 entries in flight -> out_valid=0 and err_cnt=0 without waiting for a clock edge.
- clr: clr with 2 entries in flight and err_cnt=3 -> next cycle out_valid=0, err_cnt=0, and the request presented during clr is not accepted.
